hls_mem_preload_ctrl: RTL and testbench
=======================================

Name: hls_mem_preload_ctrl

Overview:
- Upstream driver for the Bambu-generated `main` accelerator.
- Accepts a byte stream of initial memory contents and writes it byte-by-byte into `main`'s slave RAM port, channel 0.
- Then pulses start_port, waits for done_port and reports the run's cycle count, or a timeout.
- Synthesisable replacement for the file-driven preload and timing logic, for on-board runs.

Parameters:
- ADDR_W, 9, width of one channel's slave address.
- DATA_W, 64, width of one channel's slave write data.
- CNT_W, 32, width of cycle counter.
- TIMEOUT_CYCLES, 200000000, run length (in cycles, counted from start_port) at which the run is aborted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cfg_go  in  1  one-cycle pulse; begins load-then-run sequence (ignored unless IDLE)
- cfg_base_addr  in  ADDR_W  first byte address, sampled on cfg_go
- cfg_num_bytes  in  ADDR_W+1  bytes to load, sampled on cfg_go; 0 = skip load
- in_data  in  8  preload byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- S_oe_ram  out  2  slave read enable; [1] tied 0
- S_we_ram  out  2  slave write enable; [1] tied 0
- S_addr_ram  out  2*ADDR_W  slave address; upper channel 0
- S_Wdata_ram  out  2*DATA_W  slave write data; byte in [7:0], rest 0
- S_data_ram_size  out  14  access size in bits; channel 0 = 8, channel 1 = 0
- Sout_Rdata_ram  in  2*DATA_W  slave read data
- Sout_DataRdy  in  2  slave access complete; only [0] used
- start_port  out  1  start pulse to main
- done_port  in  1  completion from main
- busy  out  1  not IDLE
- run_done  out  1  sticky; run completed normally
- run_timeout  out  1  sticky; run aborted
- cycle_count  out  CNT_W  cycles from start to done

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All outputs 0, including cycle_count, run_done and run_timeout.
  - Applies mid-operation: any in-flight slave access is abandoned and start_port is dropped.
- IDLE, on cfg_go:
  - Latch base address and byte count; byte index := 0.
  - Clear run_done, run_timeout and cycle_count.
  - Next state FETCH, or START if cfg_num_bytes==0.
- FETCH:
  - in_ready=1.
  - On in_valid: latch the byte and go to WRITE.
  - in_ready is high only in FETCH, so the stream is stalled during slave accesses.
- WRITE:
  - S_we_ram[0]=1, S_addr_ram[ADDR_W-1:0]=base+index (mod 2^ADDR_W wrap), data and size as above.
  - Signals are held until Sout_DataRdy[0]==1, then index++.
  - If index reaches count: go to START, or VERIFY when the optional feature is enabled. Otherwise go to FETCH.
- START:
  - start_port=1 for exactly one cycle (T0); cycle counter := 0.
  - Next state RUN.
- RUN:
  - Counter increments every cycle; done_port is sampled every cycle.
  - On done_port==1 at cycle Tn: cycle_count := n (minimum 1), run_done := 1, go to IDLE.
  - done_port high during START is ignored.
- Timeout: if the counter reaches TIMEOUT_CYCLES in RUN with no done, set run_timeout := 1, cycle_count := TIMEOUT_CYCLES, go to IDLE.
- Simultaneous done and timeout in the same cycle: done wins.
- Counter saturates at all-ones and never wraps.
- cfg_go while busy is ignored.
- Stray Sout_DataRdy outside WRITE/VERIFY is ignored.

Optional Feature:
- Macro: HLS_PRELOAD_READBACK_EN.
- Defined:
  - After the last write, state VERIFY re-reads each byte with S_oe_ram[0]=1, addresses base..base+count-1, size 8.
  - Each access completes on Sout_DataRdy[0]; Sout_Rdata_ram[7:0] is compared against a shadow copy held in a 2^ADDR_W x 8 register array.
  - Extra output verify_err (1 bit, sticky, cleared on cfg_go) is set on any mismatch.
  - START proceeds regardless of mismatches.
- Not defined: no shadow array, no VERIFY state, no verify_err port; WRITE goes directly to START.

Test Plan:
- Reset mid-WRITE (reset low for 1 cycle while S_we_ram[0]=1): next cycle all outputs 0 and state IDLE; a following cfg_go works normally.
- Basic load:
  - Stimulus: base=0x10, count=4, bytes 0xA1..0xA4, DataRdy returned 2 cycles after each we.
  - Required: four writes to 0x10..0x13 with matching data, size field 8.
  - Then exactly one start_port pulse; done_port high 37 cycles after start; cycle_count=37 and run_done=1.
- Wrap and back-pressure: base=0x1FE, count=3, in_valid toggling -> writes go to 0x1FE, 0x1FF, 0x000; in_ready is never high during WRITE.
- Zero-length: count=0 -> no S_we_ram activity; start_port pulses the cycle after cfg_go; a done after 1 cycle gives cycle_count=1.
- Timeout: TIMEOUT_CYCLES=50, done never asserted -> run_timeout=1, cycle_count=50, busy=0; a late done_port is ignored.
- HLS_PRELOAD_READBACK_EN:
  - Write 0x55 to address 5; model returns 0x54 on the readback -> verify_err=1 and start still issued.
  - Correct readback -> verify_err=0.

Source files
------------

// File: rtl/hls_mem_preload_ctrl.sv
// hls_mem_preload_ctrl: streams preload bytes into main's slave RAM port, then starts and times one run.
// Define HLS_PRELOAD_READBACK_EN to re-read every written byte and flag mismatches on verify_err.
module hls_mem_preload_ctrl #(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 64,
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 200000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_go,
   input  logic [ADDR_W-1:0]     cfg_base_addr,
   input  logic [ADDR_W:0]       cfg_num_bytes,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [1:0]            S_oe_ram,
   output logic [1:0]            S_we_ram,
   output logic [2*ADDR_W-1:0]   S_addr_ram,
   output logic [2*DATA_W-1:0]   S_Wdata_ram,
   output logic [13:0]           S_data_ram_size,
   input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
   input  logic [1:0]            Sout_DataRdy,
   output logic                  start_port,
   input  logic                  done_port,
   output logic                  busy,
   output logic                  run_done,
   output logic                  run_timeout,
   output logic [CNT_W-1:0]      cycle_count
`ifdef HLS_PRELOAD_READBACK_EN
   ,
   output logic                  verify_err
`endif
);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
   typedef enum logic [2:0] {
      IDLE, FETCH, WRITE, START, RUN
`ifdef HLS_PRELOAD_READBACK_EN
      , VERIFY
`endif
   } state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, addr;
   logic [ADDR_W:0]   num_q, num_d, idx_q, idx_d, idx_inc;
   logic [7:0]        byte_q, byte_d;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d, cnt_nxt, cnt_out_q, cnt_out_d;
   logic              done_q, done_d, tmo_q, tmo_d;
   logic              acc_we, acc_oe, acc;
   logic              unused_ok;
`ifdef HLS_PRELOAD_READBACK_EN
   logic [7:0]        shadow [2**ADDR_W];
   logic              verr_q, verr_d;
   // Shadow copy of every completed write, used as the readback reference
   always_ff @(posedge clock) if (acc_we && Sout_DataRdy[0]) shadow[addr] <= byte_q;
   assign verify_err = verr_q;
`endif
   assign idx_inc   = idx_q + (ADDR_W+1)'(1);
   assign addr      = base_q + idx_q[ADDR_W-1:0];
   assign cnt_nxt   = &run_cnt_q ? run_cnt_q : run_cnt_q + CNT_W'(1);
   assign acc       = acc_we | acc_oe;
   assign busy      = state_q != IDLE;
   assign S_we_ram  = {1'b0, acc_we};
   assign S_oe_ram  = {1'b0, acc_oe};
   assign S_addr_ram      = {{ADDR_W{1'b0}}, acc ? addr : {ADDR_W{1'b0}}};
   assign S_Wdata_ram     = {{(2*DATA_W-8){1'b0}}, acc_we ? byte_q : 8'h00};
   assign S_data_ram_size = {7'd0, acc ? 7'd8 : 7'd0};
   assign run_done    = done_q;
   assign run_timeout = tmo_q;
   assign cycle_count = cnt_out_q;
   assign unused_ok   = ^{Sout_Rdata_ram, Sout_DataRdy[1]};
   // Next-state and strobe logic for the load / verify / start / run sequence
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      idx_d      = idx_q;
      byte_d     = byte_q;
      run_cnt_d  = run_cnt_q;
      cnt_out_d  = cnt_out_q;
      done_d     = done_q;
      tmo_d      = tmo_q;
`ifdef HLS_PRELOAD_READBACK_EN
      verr_d     = verr_q;
`endif
      in_ready   = 1'b0;
      acc_we     = 1'b0;
      acc_oe     = 1'b0;
      start_port = 1'b0;
      case (state_q)
         IDLE: if (cfg_go) begin
            base_d    = cfg_base_addr;
            num_d     = cfg_num_bytes;
            idx_d     = '0;
            done_d    = 1'b0;
            tmo_d     = 1'b0;
            cnt_out_d = '0;
`ifdef HLS_PRELOAD_READBACK_EN
            verr_d    = 1'b0;
`endif
            state_d   = cfg_num_bytes == '0 ? START : FETCH;
         end
         FETCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               byte_d  = in_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            acc_we = 1'b1;
            if (Sout_DataRdy[0]) begin
               idx_d = idx_inc;
               if (idx_inc == num_q) begin
`ifdef HLS_PRELOAD_READBACK_EN
                  idx_d   = '0;
                  state_d = VERIFY;
`else
                  state_d = START;
`endif
               end else state_d = FETCH;
            end
         end
`ifdef HLS_PRELOAD_READBACK_EN
         VERIFY: begin
            acc_oe = 1'b1;
            if (Sout_DataRdy[0]) begin
               if (Sout_Rdata_ram[7:0] != shadow[addr]) verr_d = 1'b1;
               idx_d = idx_inc;
               if (idx_inc == num_q) state_d = START;
            end
         end
`endif
         START: begin
            start_port = 1'b1;
            run_cnt_d  = '0;
            state_d    = RUN;
         end
         RUN: begin
            run_cnt_d = cnt_nxt;
            if (done_port) begin
               cnt_out_d = cnt_nxt;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else if (cnt_nxt >= TMO) begin
               cnt_out_d = TMO;
               tmo_d     = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         num_q     <= '0;
         idx_q     <= '0;
         byte_q    <= '0;
         run_cnt_q <= '0;
         cnt_out_q <= '0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
`ifdef HLS_PRELOAD_READBACK_EN
         verr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         num_q     <= num_d;
         idx_q     <= idx_d;
         byte_q    <= byte_d;
         run_cnt_q <= run_cnt_d;
         cnt_out_q <= cnt_out_d;
         done_q    <= done_d;
         tmo_q     <= tmo_d;
`ifdef HLS_PRELOAD_READBACK_EN
         verr_q    <= verr_d;
`endif
      end
   end
endmodule

// File: tb/tb_hls_mem_preload_ctrl.sv
// tb_hls_mem_preload_ctrl: scoreboard bench; stimulus queues expected writes/starts/results, a monitor checks them.
`timescale 1ns/1ps
module tb_hls_mem_preload_ctrl;
   localparam int AW = 9, DW = 64, CW = 32, TMO = 50;
   logic clock = 0, reset = 0, cfg_go = 0, in_valid = 0, done_port = 0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [AW:0] cfg_num_bytes = '0;
   logic [7:0] in_data = '0;
   logic in_ready, start_port, busy, run_done, run_timeout;
   logic [1:0] S_oe_ram, S_we_ram, Sout_DataRdy;
   logic [2*AW-1:0] S_addr_ram;
   logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
   logic [13:0] S_data_ram_size;
   logic [CW-1:0] cycle_count;
`ifdef HLS_PRELOAD_READBACK_EN
   logic verify_err;
`endif
   logic rdy = 0;
   logic [1:0] lat = 0;
   logic [7:0] mem [512];
   logic [7:0] corrupt = 0;
   logic wr_rdy_viol = 0, prev_busy = 0;
   int n_cmp = 0, n_bad = 0;
   typedef struct {int kind; int a; logic [127:0] b;} ev_t;
   ev_t sb[$];

   hls_mem_preload_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_base_addr(cfg_base_addr),
      .cfg_num_bytes(cfg_num_bytes), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
      .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
      .start_port(start_port), .done_port(done_port), .busy(busy), .run_done(run_done),
      .run_timeout(run_timeout), .cycle_count(cycle_count)
`ifdef HLS_PRELOAD_READBACK_EN
      , .verify_err(verify_err)
`endif
   );

   always #5 clock = ~clock;
   assign Sout_DataRdy   = {1'b0, rdy};
   assign Sout_Rdata_ram = {120'd0, mem[S_addr_ram[8:0]] ^ corrupt};

   // Slave RAM model: completes each access two cycles after it appears
   always @(posedge clock) begin
      if (!reset) begin
         rdy <= 0;
         lat <= 0;
      end else if (rdy) begin
         rdy <= 0;
         lat <= 0;
         if (S_we_ram[0]) mem[S_addr_ram[8:0]] <= S_Wdata_ram[7:0];
      end else if (S_we_ram[0] | S_oe_ram[0]) begin
         rdy <= lat == 1;
         lat <= lat + 1;
      end else lat <= 0;
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pop(output bit ok, output ev_t e);
      ok = sb.size() != 0;
      e = '{-1, 0, '0};
      if (ok) e = sb.pop_front();
      else begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: DUT produced an event with empty scoreboard at %0t", $time);
      end
   endtask

   // Monitor: compares each completed write, start pulse and run result against the scoreboard
   always @(negedge clock) begin
      bit ok;
      ev_t e;
      if (reset) begin
         if (S_we_ram[0] && in_ready) wr_rdy_viol = 1;
         if (S_we_ram[0] && Sout_DataRdy[0]) begin
            pop(ok, e);
            if (ok) begin
               chk("wr_kind", e.kind, 0);
               chk("wr_addr", S_addr_ram, e.a);
               chk("wr_data", S_Wdata_ram, e.b);
               chk("wr_size", S_data_ram_size, 8);
            end
         end
         if (start_port) begin
            pop(ok, e);
            if (ok) chk("start_kind", e.kind, 1);
         end
         if (prev_busy && !busy && (run_done || run_timeout)) begin
            pop(ok, e);
            if (ok) begin
               chk("res_kind", e.kind, 2);
               chk("res_count", cycle_count, e.a);
               chk("res_flags", {run_done, run_timeout}, e.b);
            end
         end
      end
      prev_busy = busy;
   end

   task automatic tick; @(posedge clock); #1; endtask
   task automatic push_wr(input int a, input int d); sb.push_back('{0, a, 128'(d)}); endtask
   task automatic push_st; sb.push_back('{1, 0, '0}); endtask
   task automatic push_res(input int c, input int f); sb.push_back('{2, c, 128'(f)}); endtask

   task automatic go(input int base, input int n);
      cfg_base_addr = AW'(base);
      cfg_num_bytes = (AW+1)'(n);
      cfg_go = 1;
      tick;
      cfg_go = 0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) tick;
      in_data = b;
      in_valid = 1;
      while (!in_ready && t < 100) begin tick; t++; end
      tick;
      in_valid = 0;
   endtask

   task automatic wait_start;
      int t = 0;
      while (!start_port && t < 200) begin tick; t++; end
      chk("start_wait", start_port, 1);
   endtask

   task automatic finish_run(input int n);
      repeat (n) tick;
      done_port = 1;
      tick;
      done_port = 0;
   endtask

   task automatic wait_idle;
      int t = 0;
      while (busy && t < 200) begin tick; t++; end
      chk("idle_wait", busy, 0);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_we_oe"}, {S_we_ram, S_oe_ram}, 0);
      chk({nm, "_addr_data_size"}, {S_addr_ram, S_Wdata_ram, S_data_ram_size}, 0);
      chk({nm, "_ready_start_busy"}, {in_ready, start_port, busy}, 0);
      chk({nm, "_done_tmo_count"}, {run_done, run_timeout, cycle_count}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t;
      for (int i = 0; i < 512; i++) mem[i] = 0;
      repeat (3) tick;
      chk_idle("por");
      reset = 1;
      tick;
      // abort during a write, then confirm everything is idle
      go('h020, 2);
      send(8'h11, 0);
      t = 0;
      while (!S_we_ram[0] && t < 50) begin tick; t++; end
      chk("rst_we_seen", S_we_ram[0], 1);
      reset = 0;
      tick;
      reset = 1;
      chk_idle("rst_mid");
      tick;
      // basic load of four bytes then a 37-cycle run
      for (int i = 0; i < 4; i++) push_wr('h10 + i, 'hA1 + i);
      push_st;
      push_res(37, 2'b10);
      go('h10, 4);
      for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 0);
      wait_start;
      finish_run(37);
      wait_idle;
      // address wrap with gaps in the input stream
      push_wr('h1FE, 'h31);
      push_wr('h1FF, 'h32);
      push_wr('h000, 'h33);
      push_st;
      push_res(5, 2'b10);
      go('h1FE, 3);
      send(8'h31, 1);
      send(8'h32, 2);
      send(8'h33, 1);
      wait_start;
      finish_run(5);
      wait_idle;
      // zero-length load: start the cycle right after cfg_go, done after one cycle
      push_st;
      push_res(1, 2'b10);
      go('h40, 0);
      chk("zl_start_next_cycle", start_port, 1);
      finish_run(1);
      wait_idle;
      // done arriving exactly at the timeout limit takes priority
      push_st;
      push_res(TMO, 2'b10);
      go(0, 0);
      finish_run(TMO);
      wait_idle;
      // timeout with no done, then a late done is ignored
      push_st;
      push_res(TMO, 2'b01);
      go('h7, 0);
      wait_idle;
      done_port = 1;
      repeat (2) tick;
      done_port = 0;
      tick;
      chk("late_done_ignored", {busy, run_done, run_timeout, cycle_count}, {3'b001, 32'(TMO)});
`ifdef HLS_PRELOAD_READBACK_EN
      corrupt = 8'h01;
      push_wr(5, 'h55);
      push_st;
      push_res(3, 2'b10);
      go(5, 1);
      send(8'h55, 0);
      wait_start;
      chk("verr_mismatch", verify_err, 1);
      finish_run(3);
      wait_idle;
      corrupt = 8'h00;
      push_wr(5, 'h55);
      push_st;
      push_res(3, 2'b10);
      go(5, 1);
      send(8'h55, 0);
      wait_start;
      chk("verr_clean", verify_err, 0);
      finish_run(3);
      wait_idle;
`endif
      repeat (5) tick;
      chk("scoreboard_drained", sb.size(), 0);
      chk("in_ready_during_write", wr_rdy_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
